// File: rtl/timer_mmio_bridge.sv
// CPU-side front end for the quarter-second timer: one Start pulse per requested tick,
// finish pulses counted down to a sticky DONE, clear-on-read STATUS at BASE_ADDR+1.
module timer_mmio_bridge #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          CNT_W     = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic        WrEn,
  input  logic [15:0] WrData,
  input  logic        RdEn,
  output logic [15:0] RdData,
  output logic        TimerStart,
  input  logic        TimerFinish,
  input  logic        TimerBusy,
  output logic        Done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd1;

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic             err;
  logic             abort;

  logic [CNT_W-1:0] cnt_req;
  logic [7:0]       rem_field;
  logic [15:0]      status;
  logic             ctrl_wr, status_rd, cnt_zero;
  logic             accept, refuse, cancel;
  logic             tick_done, last_tick, drain_exit;
  logic             unused_wrdata;

  assign cnt_req       = WrData[CNT_W-1:0];
  assign unused_wrdata = ^WrData[15:CNT_W];
  assign rem_field     = 8'(remaining);

  assign ctrl_wr   = WrEn && (Addr == BASE_ADDR);
  assign status_rd = RdEn && (Addr == STATUS_ADDR);
  assign cnt_zero  = (cnt_req == '0);

  // A timer left running by a bridge reset must finish before a new request is taken.
  assign accept = ctrl_wr && !cnt_zero && (state == IDLE) && !TimerBusy;
  assign refuse = ctrl_wr && !cnt_zero && !accept;
  assign cancel = ctrl_wr && cnt_zero && ((state == START) || (state == WAIT));

  // A cancel arriving with a finish pulse wins; the pulse is then absorbed by DRAIN.
  assign tick_done  = (state == WAIT) && TimerFinish && !cancel;
  assign last_tick  = tick_done && (remaining == CNT_W'(1));
  assign drain_exit = (state == DRAIN) && abort && (TimerFinish || !TimerBusy);

  assign status = {rem_field, 5'b0, err, (state != IDLE), Done};
  assign RdData = status_rd ? status : 16'h0000;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      remaining  <= '0;
      TimerStart <= 1'b0;
      Done       <= 1'b0;
      err        <= 1'b0;
      abort      <= 1'b0;
    end else begin
      TimerStart <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= START;
            remaining  <= cnt_req;
            TimerStart <= 1'b1;
          end
        end
        START: state <= cancel ? DRAIN : WAIT;
        WAIT: begin
          if (cancel) begin
            state <= DRAIN;
          end else if (tick_done) begin
            state      <= last_tick ? IDLE : START;
            TimerStart <= !last_tick;
          end
        end
        DRAIN: begin
          if (drain_exit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (cancel) begin
        remaining <= '0;
        abort     <= 1'b1;
      end else if (tick_done && (remaining != '0)) begin
        remaining <= remaining - CNT_W'(1);
      end
      if (drain_exit) abort <= 1'b0;

      // Set events beat the clear-on-read in the same cycle.
      if (last_tick)                Done <= 1'b1;
      else if (accept || status_rd) Done <= 1'b0;

      if (refuse)         err <= 1'b1;
      else if (status_rd) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_mmio_bridge.sv
// Bench for timer_mmio_bridge: timer model with QuarterSecond=10, directed scenarios
// followed by random CPU traffic, all outputs checked through expectation queues.
module tb_timer_mmio_bridge;

  localparam logic [15:0] CTRL_A = 16'hFF00;
  localparam logic [15:0] STAT_A = 16'hFF01;
  localparam int          QS     = 10;
  localparam int          WAIT_LIMIT = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wr_data = 16'h0000;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        timer_start;
  logic        done;

  logic t_fin  = 1'b0;
  logic t_busy = 1'b0;
  int   t_cnt  = 0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          start_q[$];
  int          done_q[$];
  logic [15:0] rd_q[$];

  // Reference state: mode 0 = idle, 1 = running a request, 2 = draining a cancelled one.
  int   m_mode = 0;
  int   m_rem  = 0;
  bit   m_done = 1'b0;
  bit   m_err  = 1'b0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  timer_mmio_bridge dut (
    .CLK        (clk),
    .Reset      (rst),
    .Addr       (addr),
    .WrEn       (wr_en),
    .WrData     (wr_data),
    .RdEn       (rd_en),
    .RdData     (rd_data),
    .TimerStart (timer_start),
    .TimerFinish(t_fin),
    .TimerBusy  (t_busy),
    .Done       (done)
  );

  // Quarter-second timer: not resettable, ignores Start while counting.
  always @(posedge clk) begin
    t_fin <= 1'b0;
    if (t_busy) begin
      if (t_cnt == 0) begin
        t_busy <= 1'b0;
        t_fin  <= 1'b1;
      end else begin
        t_cnt <= t_cnt - 1;
      end
    end else if (timer_start === 1'b1) begin
      t_busy <= 1'b1;
      t_cnt  <= QS - 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] model_status();
    model_status = {8'(m_rem), 5'b0, m_err, (m_mode != 0), m_done};
  endfunction

  // Behavioural model: advances once per clock from the inputs of the ending cycle.
  always @(posedge clk) begin
    int old_mode;
    int n;
    bit ctrl_wr, st_rd, set_done, set_err;
    cyc = cyc + 1;
    ctrl_wr = (wr_en === 1'b1) && (addr == CTRL_A);
    st_rd   = (rd_en === 1'b1) && (addr == STAT_A);
    n       = int'(wr_data[7:0]);
    if (rst) begin
      m_mode = 0;
      m_rem  = 0;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      old_mode = m_mode;
      set_done = 1'b0;
      set_err  = 1'b0;
      if (ctrl_wr && n > 0) begin
        if (old_mode == 0 && !t_busy) begin
          m_mode = 1;
          m_rem  = n;
          m_done = 1'b0;
          start_q.push_back(cyc);
        end else begin
          set_err = 1'b1;
        end
      end else if (ctrl_wr && old_mode == 1) begin
        m_mode = 2;
        m_rem  = 0;
      end
      if (old_mode == 1 && m_mode == 1 && t_fin) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_mode   = 0;
          set_done = 1'b1;
          done_q.push_back(cyc);
        end else begin
          start_q.push_back(cyc);
        end
      end
      if (old_mode == 2 && (t_fin || !t_busy)) m_mode = 0;
      if (st_rd) begin
        m_done = 1'b0;
        m_err  = 1'b0;
      end
      if (set_done) m_done = 1'b1;
      if (set_err)  m_err  = 1'b1;
    end
  end

  // Monitor: mid-cycle comparison of every DUT output against the queued expectations.
  always @(negedge clk) begin
    if (start_q.size() > 0 && start_q[0] == cyc) begin
      check("start_pulse", 64'(timer_start), 64'd1);
      void'(start_q.pop_front());
    end else if (timer_start !== 1'b0) begin
      check("start_unexpected", 64'(timer_start), 64'd0);
    end

    if (done_q.size() > 0 && done_q[0] == cyc) begin
      check("done_rise", {62'b0, prev_done, done}, 64'b01);
      void'(done_q.pop_front());
    end else if (done === 1'b1 && prev_done !== 1'b1) begin
      check("done_unexpected", 64'(done), 64'd0);
    end
    prev_done = done;

    if (rd_en === 1'b1) begin
      if (rd_q.size() == 0) check("rd_unexpected", 64'(rd_en), 64'd0);
      else                  check("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
    end else if (rd_data !== 16'h0000) begin
      check("rd_idle", 64'(rd_data), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    addr    = a;
    wr_data = d;
    step();
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] exp);
    rd_en = 1'b1;
    addr  = a;
    rd_q.push_back(exp);
    step();
  endtask

  // which: 0 = TimerFinish high, 1 = Done high, 2 = TimerBusy low
  function automatic bit cond_met(input int which);
    case (which)
      0:       cond_met = (t_fin === 1'b1);
      1:       cond_met = (done === 1'b1);
      default: cond_met = (t_busy === 1'b0);
    endcase
  endfunction

  task automatic wait_until(input int which, input string name);
    int n;
    n = 0;
    while (!cond_met(which) && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    check(name, 64'(n < WAIT_LIMIT), 64'd1);
  endtask

  initial begin
    int r;
    int n;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_timer_start", 64'(timer_start), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    do_read(STAT_A, 16'h0000);

    // Three ticks, then clear-on-read of DONE.
    do_write(CTRL_A, 16'd3);
    wait_until(1, "wait_done_t1");
    do_read(STAT_A, 16'h0001);
    do_read(STAT_A, 16'h0000);

    // Request while busy is refused and flagged.
    do_write(CTRL_A, 16'd2);
    step();
    step();
    do_write(CTRL_A, 16'd5);
    do_read(STAT_A, 16'h0206);
    wait_until(1, "wait_done_t3");
    do_read(STAT_A, 16'h0001);

    // Cancel after the first finish: drain the running tick, no more starts.
    do_write(CTRL_A, 16'd4);
    wait_until(0, "wait_fin_t4");
    step();
    step();
    do_write(CTRL_A, 16'd0);
    do_read(STAT_A, 16'h0002);
    wait_until(2, "wait_idle_t4");
    step();
    step();
    do_read(STAT_A, 16'h0000);

    // Reset mid-count: starts refused until the orphaned timer run ends.
    do_write(CTRL_A, 16'd3);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    do_write(CTRL_A, 16'd2);
    do_read(STAT_A, 16'h0004);
    wait_until(2, "wait_idle_t5");
    step();
    do_write(CTRL_A, 16'd2);
    wait_until(1, "wait_done_t5");
    do_read(STAT_A, 16'h0001);

    // Read in the very cycle DONE sets: old value returned, set wins.
    do_write(CTRL_A, 16'd1);
    wait_until(0, "wait_fin_t6");
    do_read(STAT_A, 16'h0102);
    check("done_after_race", 64'(done), 64'd1);
    do_read(STAT_A, 16'h0001);
    do_read(STAT_A, 16'h0000);

    // Random CPU traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else if (r < 8) begin
        n = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 4);
        do_write(CTRL_A, {8'($urandom), 8'(n)});
      end else if (r < 10) begin
        do_write(CTRL_A ^ 16'($urandom_range(1, 65535)), 16'($urandom));
      end else if (r < 32) begin
        do_read(STAT_A, model_status());
      end else if (r < 35) begin
        do_read(STAT_A ^ 16'($urandom_range(1, 65535)), 16'h0000);
      end else begin
        step();
      end
    end

    repeat (60) step();
    do_read(STAT_A, model_status());
    check("start_q_drained", 64'(start_q.size()), 64'd0);
    check("done_q_drained", 64'(done_q.size()), 64'd0);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
